mem_bus_mux: RTL and testbench

Shared-memory access sequencer for the multi-core system. It collects per-core memory requests and offers them to the round-robin `Arbiter` for exactly one arbitration cycle. It latches the one-hot winner from `core_select` and drives that core's transaction onto the single shared memory port. It then returns read data, a done pulse, and an optional timeout error to the winning core. One transaction is in flight at a time.

---
 rtl/mem_bus_pkg.sv | 20 ++
 rtl/mem_bus_mux_if.sv | 38 +++
 rtl/onehot_to_index.sv | 21 ++
 rtl/mem_bus_mux.sv | 135 +++++++++++++
 tb/tb_mem_bus_mux.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and sizing helpers for the shared-memory access sequencer.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArb,
        StIssue,
        StDone
    } state_e;

    // A zero TIMEOUT still needs a 1-bit counter to keep the datapath legal.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_mux_if.sv
// Core-side, arbiter-side and memory-side signals of the access sequencer.
interface mem_bus_mux_if #(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32
);
    logic [NUM_ENTRIES-1:0]            core_req;
    logic [NUM_ENTRIES-1:0]            core_we;
    logic [NUM_ENTRIES*ADDR_WIDTH-1:0] core_addr;
    logic [NUM_ENTRIES*DATA_WIDTH-1:0] core_wdata;
    logic [NUM_ENTRIES-1:0]            core_done;
    logic [NUM_ENTRIES-1:0]            core_err;
    logic [DATA_WIDTH-1:0]             core_rdata;
    logic [NUM_ENTRIES-1:0]            arb_request;
    logic [NUM_ENTRIES-1:0]            core_select;
    logic                              mem_req;
    logic                              mem_we;
    logic [ADDR_WIDTH-1:0]             mem_addr;
    logic [DATA_WIDTH-1:0]             mem_wdata;
    logic                              mem_ready;
    logic [DATA_WIDTH-1:0]             mem_rdata;
    logic                              busy;

    // Sequencer side.
    modport master (
        input  core_req, core_we, core_addr, core_wdata, core_select, mem_ready, mem_rdata,
        output core_done, core_err, core_rdata, arb_request, mem_req, mem_we, mem_addr,
               mem_wdata, busy
    );

    // Cores, arbiter and memory.
    modport slave (
        output core_req, core_we, core_addr, core_wdata, core_select, mem_ready, mem_rdata,
        input  core_done, core_err, core_rdata, arb_request, mem_req, mem_we, mem_addr,
               mem_wdata, busy
    );

endinterface

// File: rtl/onehot_to_index.sv
// Encodes a one-hot grant vector into a binary index.
module onehot_to_index
    import mem_bus_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned IDX_WIDTH   = idx_width(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES-1:0] onehot,
    output logic [IDX_WIDTH-1:0]   index
);

    always_comb begin
        index = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (onehot[i]) begin
                index = index | IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/mem_bus_mux.sv
// Sequences one core transaction at a time onto the shared memory port, using a single
// arbitration cycle per transaction and an optional ready timeout.
module mem_bus_mux
    import mem_bus_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT     = 255
) (
    input logic           clk,
    input logic           reset_n,
    mem_bus_mux_if.master bus
);

    localparam int unsigned IdxW = idx_width(NUM_ENTRIES);
    localparam int unsigned CntW = cnt_width(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        sel_idx;
    logic [IdxW-1:0]        owner_q, owner_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [NUM_ENTRIES-1:0] done_q, done_d;
    logic [NUM_ENTRIES-1:0] err_q, err_d;
    logic [NUM_ENTRIES-1:0] owner_onehot;
    logic                   granted;

    onehot_to_index #(
        .NUM_ENTRIES(NUM_ENTRIES),
        .IDX_WIDTH  (IdxW)
    ) u_sel_idx (
        .onehot(bus.core_select),
        .index (sel_idx)
    );

    assign granted      = |(bus.core_select & bus.core_req);
    assign owner_onehot = NUM_ENTRIES'(1) << owner_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        done_d      = '0;
        err_d       = '0;
        unique case (state_q)
            StIdle: begin
                if (|bus.core_req) state_d = StArb;
            end
            StArb: begin
                // A winner that has already withdrawn is dropped without touching memory.
                if (granted) begin
                    owner_d     = sel_idx;
                    mem_we_d    = bus.core_we[sel_idx];
                    mem_addr_d  = bus.core_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_wdata_d = bus.core_wdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
                    mem_req_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = StIssue;
                end else begin
                    state_d = StIdle;
                end
            end
            StIssue: begin
                if (bus.mem_ready) begin
                    rdata_d   = bus.mem_rdata;
                    done_d    = owner_onehot;
                    mem_req_d = 1'b0;
                    state_d   = StDone;
                end else if ((TIMEOUT != 0) && (cnt_q == CntMax)) begin
                    done_d    = owner_onehot;
                    err_d     = owner_onehot;
                    mem_req_d = 1'b0;
                    state_d   = StDone;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            done_q      <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Gated by reset_n so the request vector is zero while reset is held.
    assign bus.arb_request = ((state_q == StIdle) && reset_n) ? bus.core_req : '0;
    assign bus.busy        = (state_q != StIdle);
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.core_rdata  = rdata_q;
    assign bus.core_done   = done_q;
    assign bus.core_err    = err_q;

endmodule

// File: tb/tb_mem_bus_mux.sv
// Self-checking bench: vector table, hand-written corner sequences and randomized transactions.
module tb_mem_bus_mux;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 4;

    typedef struct {
        int           core;
        logic         we;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [31:0]  rdata;
        int           waits;
        int           exp_len;
        logic         exp_err;
        logic [31:0]  exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   rr_last;
    logic [DW-1:0] model_rdata;
    vec_t vecs[5];

    always #5 clk = ~clk;

    mem_bus_mux_if #(.NUM_ENTRIES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_bus_mux #(
        .NUM_ENTRIES(N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (T)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return 0;
    endfunction

    // Round-robin arbiter stand-in, registered grant, reset from ~reset_n.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.core_select <= '0;
            rr_last         <= N - 1;
        end else if (bus.arb_request != '0) begin
            bus.core_select <= N'(1) << rr_pick(bus.arb_request, rr_last);
            rr_last         <= rr_pick(bus.arb_request, rr_last);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_arb_request"}, 64'(bus.arb_request), 0);
        chk({tag, "_core_done"},   64'(bus.core_done), 0);
        chk({tag, "_core_err"},    64'(bus.core_err), 0);
        chk({tag, "_core_rdata"},  64'(bus.core_rdata), 0);
        chk({tag, "_mem_req"},     64'(bus.mem_req), 0);
        chk({tag, "_mem_we"},      64'(bus.mem_we), 0);
        chk({tag, "_mem_addr"},    64'(bus.mem_addr), 0);
        chk({tag, "_mem_wdata"},   64'(bus.mem_wdata), 0);
        chk({tag, "_busy"},        64'(bus.busy), 0);
    endtask

    // Runs one single-core transaction from IDLE; memory answers after `waits` wait cycles.
    task automatic do_txn(input int c, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] rd, input int waits,
                          input int exp_len, input logic exp_err, input logic [DW-1:0] exp_rdata);
        int n;
        logic [N-1:0] own;
        own = N'(1) << c;
        bus.core_addr  = {$urandom, $urandom, $urandom, $urandom};
        bus.core_wdata = {$urandom, $urandom, $urandom, $urandom};
        bus.core_we    = N'($urandom);
        bus.core_addr[c*AW +: AW]  = a;
        bus.core_wdata[c*DW +: DW] = wd;
        bus.core_we[c] = we;
        bus.core_req   = own;
        #1;
        chk("arb_request_idle", 64'(bus.arb_request), 64'(own));
        chk("busy_idle", 64'(bus.busy), 0);
        @(negedge clk);
        chk("arb_request_arb", 64'(bus.arb_request), 0);
        chk("mem_req_arb", 64'(bus.mem_req), 0);
        chk("busy_arb", 64'(bus.busy), 1);
        @(negedge clk);
        n = 0;
        while (bus.mem_req === 1'b1 && n < 300) begin
            n++;
            if (n == 1) begin
                chk("mem_addr", 64'(bus.mem_addr), 64'(a));
                chk("mem_we", 64'(bus.mem_we), 64'(we));
                chk("mem_wdata", 64'(bus.mem_wdata), 64'(wd));
            end
            bus.mem_ready = (n == waits + 1);
            bus.mem_rdata = (n == waits + 1) ? rd : DW'($urandom);
            @(negedge clk);
        end
        bus.mem_ready = 1'b0;
        chk("mem_req_len", 64'(n), 64'(exp_len));
        chk("core_done", 64'(bus.core_done), 64'(own));
        chk("core_err", 64'(bus.core_err), exp_err ? 64'(own) : 0);
        chk("core_rdata", 64'(bus.core_rdata), 64'(exp_rdata));
        bus.core_req = '0;
        @(negedge clk);
        chk("core_done_clear", 64'(bus.core_done), 0);
        chk("core_err_clear", 64'(bus.core_err), 0);
        chk("busy_after", 64'(bus.busy), 0);
    endtask

    initial begin
        int prev, last_rise, nr, nd;
        vecs[0] = '{2, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 3,  4, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{0, 1'b1, 32'h200, 32'h12345678, 32'hA5A5A5A5, 0,  1, 1'b0, 32'hA5A5A5A5};
        vecs[2] = '{3, 1'b0, 32'h3FC, 32'h0,        32'hCAFEF00D, 10, 5, 1'b1, 32'hA5A5A5A5};
        vecs[3] = '{1, 1'b0, 32'h44,  32'h0,        32'h0BADC0DE, 4,  5, 1'b0, 32'h0BADC0DE};
        vecs[4] = '{1, 1'b1, 32'h48,  32'h77,       32'h11111111, 5,  5, 1'b1, 32'h0BADC0DE};

        // Reset state, with requests pending to prove arb_request is held low.
        reset_n        = 1'b0;
        bus.core_req   = '1;
        bus.core_we    = '0;
        bus.core_addr  = '0;
        bus.core_wdata = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
        #1;
        chk_outputs_zero("reset");
        bus.core_req = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_outputs_zero("post_reset");
        model_rdata = '0;

        for (int i = 0; i < 5; i++) begin
            do_txn(vecs[i].core, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                   vecs[i].waits, vecs[i].exp_len, vecs[i].exp_err, vecs[i].exp_rdata);
            model_rdata = vecs[i].exp_rdata;
        end

        // Withdrawal during ARB.
        bus.core_req = 4'b0010;
        #1;
        chk("wd_arb_request", 64'(bus.arb_request), 64'h2);
        @(negedge clk);
        bus.core_req = '0;
        chk("wd_busy_arb", 64'(bus.busy), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wd_mem_req", 64'(bus.mem_req), 0);
            chk("wd_core_done", 64'(bus.core_done), 0);
            chk("wd_busy", 64'(bus.busy), 0);
        end

        for (int i = 0; i < 16; i++) begin
            int c, w, el;
            logic we, ee;
            logic [31:0] a, d, r, er;
            c  = $urandom_range(0, N - 1);
            w  = $urandom_range(0, 7);
            we = 1'($urandom);
            a  = $urandom;
            d  = $urandom;
            r  = $urandom;
            ee = (w > T);
            el = ee ? T + 1 : w + 1;
            er = ee ? model_rdata : r;
            do_txn(c, we, a, d, r, w, el, ee, er);
            model_rdata = er;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of ISSUE.
        bus.core_req = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_mem_req", 64'(bus.mem_req), 1);
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("mid_reset");
        bus.core_req = '0;
        @(negedge clk);
        reset_n = 1'b1;
        model_rdata = '0;
        @(negedge clk);
        do_txn(3, 1'b0, 32'h500, 32'h0, 32'h600DF00D, 1, 2, 1'b0, 32'h600DF00D);

        // Contention with zero-wait memory, starting from a freshly reset arbiter.
        reset_n = 1'b0;
        #1;
        @(negedge clk);
        reset_n = 1'b1;
        bus.core_req  = '1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5555AAAA;
        prev = 0;
        last_rise = -1;
        nr = 0;
        nd = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            if (bus.mem_req === 1'b1 && prev == 0) begin
                if (last_rise >= 0) chk("rise_spacing", 64'(cyc - last_rise), 4);
                last_rise = cyc;
                nr++;
            end
            prev = (bus.mem_req === 1'b1) ? 1 : 0;
            if (bus.core_done != '0) begin
                chk("grant_order", 64'(bus.core_done), 64'(N'(1) << (nd % N)));
                nd++;
            end
        end
        chk("contention_rises", 64'(nr), 6);
        chk("contention_dones", 64'(nd), 6);
        bus.core_req  = '0;
        bus.mem_ready = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
